mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit that sits beside the ALU in the execute stage of the pipelined CPU.
- Consumes the same two register operands the ALU receives: rs value on A1, rt value on A2.
- Implements mult, multu, div, divu, mthi and mtlo with fixed multi-cycle latency.
- Holds the architectural HI/LO registers, which mfhi/mflo read. The hazard unit stalls the pipeline on busy.

Parameters:
- MULT_CYCLES, default 5: busy duration in cycles for mult/multu. Legal range 1..15.
- DIV_CYCLES, default 10: busy duration in cycles for div/divu. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  qualifies mdu_op for exactly one cycle.
- mdu_op  input  3  operation code (encodings in shared header).
- A1  input  32  operand 1 (rs value).
- A2  input  32  operand 2 (rt value).
- busy  output  1  registered; high while a mult/div is in flight.
- hi  output  32  registered HI register.
- lo  output  32  registered LO register.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset: hi=0, lo=0, busy=0, cycle counter=0, pending result=0.
  - Reset mid-operation aborts the operation. No HI/LO commit occurs.
  - Reset has priority over start.
- States: IDLE (counter==0, busy=0) and RUN (counter!=0, busy=1). busy is counter!=0, driven from a register.
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - On that edge, the full result is computed from A1/A2 and latched into pending {hi_p, lo_p}.
  - Counter is loaded with MULT_CYCLES or DIV_CYCLES; busy rises after the edge.
- RUN: counter decrements each edge. On the edge where counter goes 1->0, hi<=hi_p, lo<=lo_p and busy falls.
  - busy is therefore high for exactly N cycles after the start edge.
  - New hi/lo are visible in the first cycle busy=0.
- IDLE, start=1, op MTHI/MTLO: hi<=A1 (or lo<=A1) on that edge. busy stays 0; the other register is unchanged.
- start=1 with op NOP or an undefined encoding: no effect.
- start=1 while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not occur.
- Operands may change freely after the start edge; only the latched values are used.
- Arithmetic:
  - MULT: signed 32x32 -> 64, {hi,lo}=product.
  - MULTU: unsigned 32x32 -> 64, {hi,lo}=product.
  - DIV: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU: unsigned. lo=quotient, hi=remainder.
  - Divide by zero (A2==0, DIV or DIVU): busy still asserts for DIV_CYCLES; hi/lo are left unchanged at commit.
- No combinational path from inputs to outputs.

Decomposition:
- Shared constants header mdu_defs, also included by the controller:
  - MDU_NOP=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
- One combinational sub-module, mdu_calc: op, A1, A2 -> 64-bit {hi_p, lo_p} plus a div0 flag.
- mdu itself keeps the counter, pending registers and HI/LO.

Test Plan:
1. Reset then idle: hold reset 2 cycles -> busy=0, hi=0, lo=0. start=1 with op NOP -> no change.
2. MULT with A1=0xFFFFFFFE (-2), A2=3, then MULTU with the same operands:
   - MULT: busy=1 for exactly 5 cycles; lo unchanged until commit; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
   - MULTU: hi=0x00000002, lo=0xFFFFFFFA.
3. DIV -7/2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
4. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> busy 10 cycles, hi/lo keep their prior values.
5. MTHI A1=0x12345678 -> hi=0x12345678 next cycle, busy stays 0. MTLO during busy -> ignored, lo gets only the mult result.
6. Start MULT, assert reset on the 3rd busy cycle -> busy=0, hi=lo=0, and no later commit occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit opcodes and helpers; the controller imports the same package.
package mdu_pkg;

   typedef logic [2:0] mdu_op_t;

   localparam mdu_op_t MDU_NOP   = 3'd0;
   localparam mdu_op_t MDU_MULT  = 3'd1;
   localparam mdu_op_t MDU_MULTU = 3'd2;
   localparam mdu_op_t MDU_DIV   = 3'd3;
   localparam mdu_op_t MDU_DIVU  = 3'd4;
   localparam mdu_op_t MDU_MTHI  = 3'd5;
   localparam mdu_op_t MDU_MTLO  = 3'd6;

   localparam int unsigned CNT_W = 4;

   function automatic logic is_mult(input mdu_op_t op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div(input mdu_op_t op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the full {hi, lo} result and a divide-by-zero
// flag for the operation about to be launched.
module mdu_calc
   import mdu_pkg::*;
(
   input  mdu_op_t     op,
   input  logic [31:0] a1,
   input  logic [31:0] a2,
   output logic [63:0] res,
   output logic        div0
);

   logic signed [63:0] sa1, sa2;
   logic signed [31:0] squo, srem;
   logic        [31:0] uquo, urem;
   logic        [31:0] dsr;
   logic               ovf;

   assign sa1  = {{32{a1[31]}}, a1};
   assign sa2  = {{32{a2[31]}}, a2};
   // Substitute a divisor of 1 so the dividers never see zero or the overflow case.
   assign ovf  = (a1 == 32'h8000_0000) && (a2 == 32'hffff_ffff);
   assign dsr  = ((a2 == 32'd0) || ovf) ? 32'd1 : a2;

   always_comb begin
      squo = $signed(a1) / $signed(dsr);
      srem = $signed(a1) % $signed(dsr);
      uquo = a1 / dsr;
      urem = a1 % dsr;
   end

   always_comb begin
      res  = '0;
      div0 = 1'b0;
      case (op)
         MDU_MULT:  res = sa1 * sa2;
         MDU_MULTU: res = {32'd0, a1} * {32'd0, a2};
         MDU_DIV: begin
            div0 = (a2 == 32'd0);
            if (ovf) res = {32'd0, 32'h8000_0000};
            else     res = {srem, squo};
         end
         MDU_DIVU: begin
            div0 = (a2 == 32'd0);
            res  = {urem, uquo};
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: latches the result at the start edge, holds busy for a fixed latency and
// commits to the architectural HI/LO registers when the countdown expires.
module mdu
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  mdu_op_t     mdu_op,
   input  logic [31:0] A1,
   input  logic [31:0] A2,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [CNT_W-1:0] cnt_q;
   logic [31:0]      hi_p_q, lo_p_q;
   logic             div0_q;
   logic [63:0]      calc_res;
   logic             calc_div0;

   mdu_calc u_calc (
      .op   (mdu_op),
      .a1   (A1),
      .a2   (A2),
      .res  (calc_res),
      .div0 (calc_div0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         busy   <= 1'b0;
         hi_p_q <= '0;
         lo_p_q <= '0;
         div0_q <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else if (cnt_q == '0) begin
         if (start) begin
            if (is_mult(mdu_op) || is_div(mdu_op)) begin
               hi_p_q <= calc_res[63:32];
               lo_p_q <= calc_res[31:0];
               div0_q <= calc_div0;
               cnt_q  <= is_mult(mdu_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
               busy   <= 1'b1;
            end else if (mdu_op == MDU_MTHI) begin
               hi <= A1;
            end else if (mdu_op == MDU_MTLO) begin
               lo <= A1;
            end
         end
      end else begin
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            busy <= 1'b0;
            // A divide by zero keeps the previous architectural HI/LO.
            if (!div0_q) begin
               hi <= hi_p_q;
               lo <= lo_p_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed plan steps plus random ops against a plain-arithmetic model.
module tb_mdu;
   import mdu_pkg::*;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  mdu_op;
   logic [31:0] A1, A2;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   always #5 clk = ~clk;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdu_op (mdu_op),
      .A1     (A1),
      .A2     (A2),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: returns expected busy length and updates hi_m/lo_m.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      longint sa, sb, q, r;
      longint unsigned p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      cyc = 0;
      case (op)
         3'd1: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; cyc = MC; end
         3'd2: begin
            p = 64'({32'd0, a}) * 64'({32'd0, b});
            hi_m = p[63:32]; lo_m = p[31:0]; cyc = MC;
         end
         3'd3: begin
            cyc = DC;
            if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = 32'(q); hi_m = 32'(r); end
         end
         3'd4: begin
            cyc = DC;
            if (b != 0) begin lo_m = a / b; hi_m = a % b; end
         end
         3'd5: hi_m = a;
         3'd6: lo_m = a;
         default: ;
      endcase
   endtask

   task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; mdu_op = op; A1 = a; A2 = b;
      @(negedge clk);
      start = 1'b0; mdu_op = 3'd0; A1 = $urandom; A2 = $urandom;
   endtask

   // Count busy cycles (bounded), checking lo holds its old value throughout.
   task automatic wait_idle(input string tag, input logic [31:0] old_lo, output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         check({tag, " lo_hold"}, lo, old_lo);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      int cyc, n;
      logic [31:0] old_lo;
      old_lo = lo_m;
      model(op, a, b, cyc);
      pulse(op, a, b);
      wait_idle(tag, old_lo, n);
      check({tag, " busy_len"}, 32'(n), 32'(cyc));
      check({tag, " hi"}, hi, hi_m);
      check({tag, " lo"}, lo, lo_m);
   endtask

   initial begin
      int n;
      logic [2:0] op;
      logic [31:0] a, b;
      reset = 1'b1; start = 1'b0; mdu_op = 3'd0; A1 = '0; A2 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      run_op("nop", 3'd0, 32'h1111_1111, 32'h2222_2222);

      run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3);
      check("mult hi const", hi, 32'hFFFF_FFFF);
      check("mult lo const", lo, 32'hFFFF_FFFA);
      run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3);
      check("multu hi const", hi, 32'h0000_0002);
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2);
      check("div lo const", lo, 32'hFFFF_FFFD);
      check("div hi const", hi, 32'hFFFF_FFFF);
      run_op("divu", 3'd4, 32'd7, 32'd2);
      check("divu lo const", lo, 32'd3);
      check("divu hi const", hi, 32'd1);
      run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div ovf lo const", lo, 32'h8000_0000);
      check("div ovf hi const", hi, 32'd0);
      run_op("divu0", 3'd4, 32'd5, 32'd0);
      run_op("mthi", 3'd5, 32'h1234_5678, 32'd0);
      check("mthi hi const", hi, 32'h1234_5678);
      run_op("undef", 3'd7, 32'hAAAA_AAAA, 32'h5555_5555);

      // MTLO while busy must be ignored.
      begin
         int cyc;
         logic [31:0] old_lo;
         old_lo = lo_m;
         model(3'd1, 32'd6, 32'd7, cyc);
         pulse(3'd1, 32'd6, 32'd7);
         start = 1'b1; mdu_op = 3'd6; A1 = 32'hDEAD_BEEF;
         @(negedge clk);
         start = 1'b0; mdu_op = 3'd0;
         n = 1;
         check("mtlo busy lo_hold", lo, old_lo);
         wait_idle("mtlo busy", old_lo, cyc);
         check("mtlo busy len", 32'(n + cyc), 32'(MC));
         check("mtlo busy lo", lo, 32'd42);
      end

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
         run_op("rand", op, a, b);
      end

      // Reset on the 3rd busy cycle aborts the multiply.
      pulse(3'd1, 32'd100, 32'd100);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      hi_m = '0; lo_m = '0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      repeat (MC + 3) @(negedge clk);
      check("abort late hi", hi, 32'd0);
      check("abort late lo", lo, 32'd0);
      check("abort late busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
